// File: rtl/mem_access_unit.sv
// Memory stage that issues loads/stores on a variable-latency req/ack bus,
// stalls the pipeline until ack, extends load data and raises AdEL/AdES/DBE.
module mem_access_unit #(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] DM_SIZE      = 32'h0000_3000,
    parameter logic [31:0] IO_BASE      = 32'h0000_7F00,
    parameter logic [31:0] IO_SIZE      = 32'h0000_0030,
    parameter bit          IO_WORD_ONLY = 1'b1,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd_addr_in,
    input  logic [31:0]       pc_in,
    input  logic              flush,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [31:0]       wb_rdata,
    output logic [4:0]        wb_rd_addr,
    output logic [31:0]       wb_pc,
    output logic              exc_valid,
    output logic [4:0]        exc_code,
    output logic [31:0]       exc_badvaddr,
    output logic              dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] DM_END   = ADDR_W'(DM_SIZE);
    localparam logic [ADDR_W-1:0] IO_LO    = ADDR_W'(IO_BASE);
    localparam logic [ADDR_W-1:0] IO_HI    = ADDR_W'(IO_BASE + IO_SIZE);
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT - 1);

    state_t            state_q;
    logic              bus_req_q, bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q, vaddr_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       bus_wdata_q;
    logic              wb_valid_q, exc_valid_q;
    logic [31:0]       wb_rdata_q, wb_pc_q, exc_bad_q, pc_q;
    logic [4:0]        wb_rd_q, exc_code_q, rd_q;
    logic [1:0]        size_q, lane_q;
    logic              sext_q, load_q, kill_q;
    logic [15:0]       tmo_q;

    logic        is_mem, is_store, is_word, is_half, in_dm, in_io, fault;
    logic        issue, tmo_hit, killed;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, rdata_d, shifted;
    logic [4:0]  sh_amt;

    assign is_mem   = mem_rd | mem_wr;
    assign is_store = mem_wr;
    assign is_word  = mem_size[1];
    assign is_half  = (mem_size == 2'd1);
    assign in_dm    = (addr < DM_END);
    assign in_io    = (addr >= IO_LO) && (addr < IO_HI);

    always_comb begin
        fault = 1'b0;
        if ((is_half && addr[0]) || (is_word && addr[1:0] != 2'b00))
            fault = 1'b1;
        if (!in_dm && !in_io)
            fault = 1'b1;
        if (IO_WORD_ONLY && in_io && !is_word)
            fault = 1'b1;
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        if (mem_size == 2'd0) begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
        end else if (is_half) begin
            be_d    = 4'b0011 << {addr[1], 1'b0};
            wdata_d = {2{wdata[15:0]}};
        end
    end

    // Lane select uses the registered low address bits; halves only look at bit 1.
    always_comb begin
        sh_amt  = (size_q == 2'd1) ? {lane_q[1], 4'b0000} : {lane_q, 3'b000};
        shifted = bus_rdata >> sh_amt;
        case (size_q)
            2'd0:    rdata_d = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            2'd1:    rdata_d = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default: rdata_d = bus_rdata;
        endcase
    end

    assign issue   = (state_q == S_IDLE) && req_valid && !flush && is_mem && !fault;
    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign killed  = kill_q | flush;
    assign stall   = issue || ((state_q == S_WAIT) && !(bus_ack || tmo_hit));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            wb_valid_q  <= 1'b0;
            wb_rdata_q  <= 32'h0;
            wb_rd_q     <= 5'd0;
            wb_pc_q     <= 32'h0000_3000;
            exc_valid_q <= 1'b0;
            exc_code_q  <= 5'd0;
            exc_bad_q   <= 32'h0;
            vaddr_q     <= '0;
            pc_q        <= 32'h0;
            rd_q        <= 5'd0;
            size_q      <= 2'd0;
            lane_q      <= 2'd0;
            sext_q      <= 1'b0;
            load_q      <= 1'b0;
            kill_q      <= 1'b0;
            tmo_q       <= 16'd0;
        end else begin
            wb_valid_q  <= 1'b0;
            exc_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        if (!is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_rdata_q <= 32'h0;
                            wb_rd_q    <= rd_addr_in;
                            wb_pc_q    <= pc_in;
                        end else if (fault) begin
                            exc_valid_q <= 1'b1;
                            exc_code_q  <= is_store ? 5'd5 : 5'd4;
                            exc_bad_q   <= 32'(addr);
                        end else begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= is_store;
                            bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                            vaddr_q     <= addr;
                            pc_q        <= pc_in;
                            rd_q        <= rd_addr_in;
                            size_q      <= mem_size;
                            lane_q      <= addr[1:0];
                            sext_q      <= mem_sext;
                            load_q      <= !is_store;
                            kill_q      <= 1'b0;
                            tmo_q       <= 16'd0;
                            state_q     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                        state_q   <= S_IDLE;
                        if (!killed) begin
                            wb_valid_q <= 1'b1;
                            wb_rdata_q <= load_q ? rdata_d : 32'h0;
                            wb_rd_q    <= rd_q;
                            wb_pc_q    <= pc_q;
                        end
                    end else if (tmo_hit) begin
                        bus_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                        state_q   <= S_IDLE;
                        if (!killed) begin
                            exc_valid_q <= 1'b1;
                            exc_code_q  <= 5'd7;
                            exc_bad_q   <= 32'(vaddr_q);
                        end
                    end else begin
                        if (TIMEOUT != 0)
                            tmo_q <= tmo_q + 16'd1;
                        if (flush)
                            kill_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rdata     = wb_rdata_q;
    assign wb_rd_addr   = wb_rd_q;
    assign wb_pc        = wb_pc_q;
    assign exc_valid    = exc_valid_q;
    assign exc_code     = exc_code_q;
    assign exc_badvaddr = exc_bad_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts stall,
// bus fields and write-back/exception pulses; one negedge process compares.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, mem_rd, mem_wr, mem_sext, flush, bus_ack;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata, pc_in, bus_rdata;
  logic [4:0]  rd_addr_in;
  logic        bus_req, bus_we, stall, wb_valid, exc_valid, dbg_state;
  logic [31:0] bus_addr, bus_wdata, wb_rdata, wb_pc, exc_badvaddr;
  logic [3:0]  bus_be;
  logic [4:0]  wb_rd_addr, exc_code;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_sext(mem_sext), .addr(addr), .wdata(wdata),
    .rd_addr_in(rd_addr_in), .pc_in(pc_in), .flush(flush), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall), .wb_valid(wb_valid),
    .wb_rdata(wb_rdata), .wb_rd_addr(wb_rd_addr), .wb_pc(wb_pc), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_badvaddr(exc_badvaddr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // expectations for the current cycle and pulses due next cycle
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_wb, exp_exc;
  logic [31:0] exp_baddr, exp_bwdata, exp_wb_rdata, exp_wb_pc, exp_exc_bad;
  logic [3:0]  exp_be;
  logic [4:0]  exp_wb_rd, exp_exc_code;
  logic        pend_wb, pend_exc;
  logic [31:0] pend_wb_rdata, pend_wb_pc, pend_exc_bad;
  logic [4:0]  pend_wb_rd, pend_exc_code;

  // last values seen on the DUT, for literal checks
  logic [31:0] last_wb_rdata, last_bus_addr, last_bus_wdata, last_exc_bad;
  logic [3:0]  last_be;
  logic [4:0]  last_exc_code;
  logic        last_we;
  int          stall_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // model of the memory map and lane rules
  function automatic logic model_fault(input logic [1:0] size, input logic [31:0] a);
    logic mis, in_dm, in_io;
    mis   = (size == 2'd1 && a % 2 != 0) || (size >= 2'd2 && a % 4 != 0);
    in_dm = a < 32'h3000;
    in_io = a >= 32'h7F00 && a < 32'h7F30;
    return mis || !(in_dm || in_io) || (in_io && size < 2'd2);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    if (size >= 2'd2) return 4'hF;
    if (size == 2'd1) return (a % 4 >= 2) ? 4'b1100 : 4'b0011;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] size, input logic sext);
    logic [31:0] v;
    if (size >= 2'd2) return rd;
    if (size == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (sext && v >= 128) v = v - 256;
    end else begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (sext && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, exp_stall);
      chk("bus_req", bus_req, exp_req);
      chk("wb_valid", wb_valid, exp_wb);
      chk("exc_valid", exc_valid, exp_exc);
      if (exp_req) begin
        chk("bus_we", bus_we, exp_we);
        chk("bus_addr", bus_addr, exp_baddr);
        chk("bus_be", bus_be, exp_be);
        chk("bus_wdata", bus_wdata, exp_bwdata);
      end
      if (exp_wb) begin
        chk("wb_rdata", wb_rdata, exp_wb_rdata);
        chk("wb_rd_addr", wb_rd_addr, exp_wb_rd);
        chk("wb_pc", wb_pc, exp_wb_pc);
      end
      if (exp_exc) begin
        chk("exc_code", exc_code, exp_exc_code);
        chk("exc_badvaddr", exc_badvaddr, exp_exc_bad);
      end
      if (bus_req) begin
        last_bus_addr = bus_addr; last_be = bus_be; last_bus_wdata = bus_wdata; last_we = bus_we;
      end
      if (wb_valid) last_wb_rdata = wb_rdata;
      if (exc_valid) begin
        last_exc_code = exc_code; last_exc_bad = exc_badvaddr;
      end
      if (stall) stall_cnt++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
    exp_wb = pend_wb; exp_wb_rdata = pend_wb_rdata; exp_wb_rd = pend_wb_rd; exp_wb_pc = pend_wb_pc;
    exp_exc = pend_exc; exp_exc_code = pend_exc_code; exp_exc_bad = pend_exc_bad;
    pend_wb = 1'b0; pend_exc = 1'b0;
  endtask

  task automatic quiet();
    req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; flush = 1'b0; bus_ack = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      quiet();
      step();
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [1:0] size, input logic sext,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                        input int ack_wait, input int flush_at);
    logic is_mem, st, bad, killed, ack;
    logic [4:0]  rda;
    logic [31:0] pc;
    rda = 5'($urandom_range(1, 31));
    pc  = 32'h3000 + 32'($urandom_range(0, 255)) * 4;
    is_mem = rd | wr;
    st     = wr;
    bad    = is_mem && model_fault(size, a);
    req_valid = 1'b1; mem_rd = rd; mem_wr = wr; mem_size = size; mem_sext = sext;
    addr = a; wdata = d; rd_addr_in = rda; pc_in = pc; flush = 1'b0; bus_ack = 1'b0;
    stall_cnt = 0;
    exp_stall = is_mem && !bad;
    exp_req   = 1'b0;
    if (!is_mem) begin
      pend_wb = 1'b1; pend_wb_rdata = 32'h0; pend_wb_rd = rda; pend_wb_pc = pc;
    end else if (bad) begin
      pend_exc = 1'b1; pend_exc_code = st ? 5'd5 : 5'd4; pend_exc_bad = a;
    end
    step();
    if (is_mem && !bad) begin
      exp_we = st; exp_baddr = a & ~32'h3; exp_be = model_be(size, a);
      exp_bwdata = model_wdata(size, d);
      killed = 1'b0;
      for (int w = 1; w <= 20; w++) begin
        ack = (w == ack_wait);
        bus_ack = ack;
        bus_rdata = ack ? rdata : $urandom;
        flush = (w == flush_at);
        if (w == flush_at) killed = 1'b1;
        exp_req = 1'b1;
        exp_stall = !(ack || w == TMO);
        if (ack) begin
          if (!killed) begin
            pend_wb = 1'b1; pend_wb_rd = rda; pend_wb_pc = pc;
            pend_wb_rdata = st ? 32'h0 : model_load(rdata, a, size, sext);
          end
          step();
          break;
        end
        if (w == TMO) begin
          if (!killed) begin
            pend_exc = 1'b1; pend_exc_code = 5'd7; pend_exc_bad = a;
          end
          step();
          break;
        end
        step();
      end
    end
    quiet();
  endtask

  task automatic check_reset_vals();
    chk("rst bus_req", bus_req, 0);
    chk("rst bus_we", bus_we, 0);
    chk("rst bus_be", bus_be, 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_wdata", bus_wdata, 0);
    chk("rst stall", stall, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_rdata", wb_rdata, 0);
    chk("rst wb_rd_addr", wb_rd_addr, 0);
    chk("rst wb_pc", wb_pc, 32'h0000_3000);
    chk("rst exc_valid", exc_valid, 0);
    chk("rst exc_code", exc_code, 0);
    chk("rst exc_badvaddr", exc_badvaddr, 0);
  endtask

  initial begin
    reset = 1'b1; mem_size = 2'd0; mem_sext = 1'b0; addr = 32'h0; wdata = 32'h0;
    rd_addr_in = 5'd0; pc_in = 32'h0; bus_rdata = 32'h0;
    pend_wb = 1'b0; pend_exc = 1'b0; pend_wb_rdata = 0; pend_wb_rd = 0; pend_wb_pc = 0;
    pend_exc_code = 0; pend_exc_bad = 0;
    quiet();
    exp_wb = 1'b0; exp_exc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // lw, ack in 4th WAIT cycle
    access(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 4, 0);
    chk("t1 stall cycles", 32'(stall_cnt), 4);
    chk("t1 bus_be", last_be, 4'hF);
    idle(1);
    chk("t1 wb_rdata", last_wb_rdata, 32'hDEAD_BEEF);

    // lb / lbu at 0x13
    access(1, 0, 2'd0, 1, 32'h13, 32'h0, 32'h8000_0000, 2, 0);
    idle(1);
    chk("t2 bus_addr", last_bus_addr, 32'h10);
    chk("t2 lb", last_wb_rdata, 32'hFFFF_FF80);
    access(1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h8000_0000, 2, 0);
    idle(1);
    chk("t2 lbu", last_wb_rdata, 32'h0000_0080);

    // sh at 0x2
    access(0, 1, 2'd1, 0, 32'h2, 32'h0000_1234, 32'h0, 1, 0);
    idle(1);
    chk("t3 bus_be", last_be, 4'b1100);
    chk("t3 bus_wdata", last_bus_wdata, 32'h1234_1234);
    chk("t3 bus_we", last_we, 1);

    // misaligned lw, sub-word IO store, range edges
    access(1, 0, 2'd2, 0, 32'h6, 32'h0, 32'h0, 1, 0);
    idle(1);
    chk("t4 adel code", last_exc_code, 5'd4);
    chk("t4 adel bad", last_exc_bad, 32'h6);
    access(0, 1, 2'd0, 0, 32'h7F01, 32'h55, 32'h0, 1, 0);
    idle(1);
    chk("t4 ades code", last_exc_code, 5'd5);
    access(1, 0, 2'd2, 0, 32'h3000, 32'h0, 32'h0, 1, 0);
    access(0, 1, 2'd2, 0, 32'h7F30, 32'h0, 32'h0, 1, 0);
    access(0, 1, 2'd2, 0, 32'h2FFC, 32'hCAFE_F00D, 32'h0, 2, 0);
    access(1, 0, 2'd3, 0, 32'h7F2C, 32'h0, 32'h1357_9BDF, 1, 0);
    // back-to-back with the previous access
    access(0, 1, 2'd0, 0, 32'h21, 32'h0000_00AB, 32'h0, 3, 0);
    access(1, 0, 2'd1, 1, 32'h2, 32'h0, 32'h8001_0000, 1, 0);
    access(1, 0, 2'd1, 0, 32'h2, 32'h0, 32'h8001_0000, 2, 0);
    idle(1);
    chk("lhu upper half", last_wb_rdata, 32'h0000_8001);

    // non-memory instruction and flush while idle
    access(0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    req_valid = 1'b1; mem_rd = 1'b1; mem_size = 2'd2; addr = 32'h40; flush = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0;
    step();
    idle(2);

    // flush in 2nd WAIT cycle, ack in 4th
    access(1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h1111_2222, 4, 2);
    chk("t5 stall cycles", 32'(stall_cnt), 4);
    idle(2);

    // timeout, then timeout under kill
    access(1, 0, 2'd2, 0, 32'h30, 32'h0, 32'h0, 0, 0);
    idle(1);
    chk("t6 dbe code", last_exc_code, 5'd7);
    chk("t6 dbe bad", last_exc_bad, 32'h30);
    access(1, 0, 2'd2, 0, 32'h34, 32'h0, 32'h0, 0, 2);
    idle(2);

    // asynchronous reset in the middle of WAIT
    req_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1; mem_size = 2'd2; addr = 32'h44;
    wdata = 32'h9999_8888; exp_stall = 1'b1; exp_req = 1'b0;
    step();
    exp_we = 1'b1; exp_baddr = 32'h44; exp_be = 4'hF; exp_bwdata = 32'h9999_8888;
    repeat (2) begin
      exp_req = 1'b1;
      step();
    end
    chk_en = 1'b0;
    quiet();
    #2 reset = 1'b1;
    #1 check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;
    pend_wb = 1'b0; pend_exc = 1'b0; exp_wb = 1'b0; exp_exc = 1'b0;
    chk_en = 1'b1;
    idle(2);
    access(1, 0, 2'd2, 0, 32'h48, 32'h0, 32'h0BAD_F00D, 2, 0);
    idle(2);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
